bpred_ctrl: RTL
===============

BPRED_CTRL -- requirements
Module: bpred_ctrl

Interface
REQ-001 SHALL have one clock and one reset, in this order: CLK input 1 (rising-edge clock), then nRST input 1 (asynchronous reset, active-low).
REQ-002 SHALL have port pc: input, 32 bits, fetch-stage PC used for lookup.
REQ-003 SHALL have port pred_taken: output, 1 bit, predict taken for pc.
REQ-004 SHALL have port pred_target: output, 32 bits, predicted target when pred_taken=1; 32'h0 otherwise.
REQ-005 SHALL have port upd_valid: input, 1 bit, resolved branch is present in the MEM stage.
REQ-006 SHALL have port upd_en: input, 1 bit, pipeline advance qualifier (ihit/dhit).
REQ-007 SHALL have port upd_pc: input, 32 bits, PC of the resolved branch.
REQ-008 SHALL have port upd_taken: input, 1 bit, actual outcome.
REQ-009 SHALL have port upd_target: input, 32 bits, actual taken target.
REQ-010 SHALL have port upd_mispredict: input, 1 bit, prediction was wrong.
REQ-011 SHALL have port clear_req: input, 1 bit, request to invalidate the whole table.
REQ-012 SHALL have port busy: output, 1 bit, high while a clear is in progress.
REQ-013 SHALL have port branch_cnt: output, 16 bits, count of resolved branches.
REQ-014 SHALL have port mispred_cnt: output, 16 bits, count of mispredicts.

Function
REQ-015 SHALL hold 16 entries; index = pc[5:2]; tag = pc[31:6]; each entry holds valid, 26-bit tag, 32-bit target and a 2-bit saturating counter.
REQ-016 SHALL make lookup combinational: pred_taken = state IDLE & valid[idx] & tag match & counter[1].
REQ-017 SHALL apply an update at the rising edge when upd_valid & upd_en & state IDLE; no update SHALL occur otherwise.
REQ-018 SHALL, on update, move the counter at upd index by +1 if upd_taken and -1 otherwise, saturating at 2'b11 and 2'b00.
REQ-019 SHALL, on update with upd_taken=1, write valid=1, tag and target.
REQ-020 SHALL, on update with upd_taken=0, leave valid, tag and target unchanged.
REQ-021 SHALL, on tag mismatch with upd_taken=1, replace the entry and set its counter to 2'b10 (weakly taken), not the incremented old value.
REQ-022 SHALL, when lookup and update hit the same index in the same cycle, have the lookup return the pre-update value (no bypass).
REQ-023 SHALL increment branch_cnt on each applied update, and mispred_cnt on each applied update with upd_mispredict=1; both SHALL saturate at 16'hFFFF.
REQ-024 SHALL implement an FSM with two states: IDLE and CLEAR.
REQ-025 SHALL move IDLE -> CLEAR on clear_req=1 and load clr_idx=0.
REQ-026 SHALL, in CLEAR, write valid=0 and counter=2'b01 to entry clr_idx each cycle, then increment clr_idx.
REQ-027 SHALL move CLEAR -> IDLE after writing clr_idx=15, so a clear lasts 16 cycles.
REQ-028 SHALL drive busy=1 exactly while in CLEAR.
REQ-029 SHALL, while in CLEAR, ignore clear_req, drop updates (no counter, table or statistics change) and force pred_taken=0.
REQ-030 SHALL give clear_req priority when clear_req and an update arrive in the same IDLE cycle: the update is dropped.

Reset
REQ-031 SHALL, on nRST=0, immediately and regardless of CLK, set all valid=0, all counters=2'b01, tags and targets to 0, branch_cnt=0, mispred_cnt=0, state=IDLE, clr_idx=0; busy=0 and pred_taken=0 follow.
REQ-032 SHALL, on reset asserted mid-clear, abort the clear and resume in IDLE on release.

Structure
REQ-033 SHALL place BPRED_IDX_W=4, BPRED_TAG_W=26, a typedef bpred_state_t {IDLE, CLEAR} and a counter enum {STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11} in cpu_types_pkg.
REQ-034 SHALL implement the saturating next-value logic as one sub-module, sat_counter2 (inputs cur, taken; output next).

Verification
REQ-035 SHALL test: after reset, lookup pc=32'h0000_0040 -> pred_taken=0, pred_target=0.
REQ-036 SHALL test: two taken updates at pc=32'h0000_0044, target=32'h0000_0100 -> counter 01->10->11; lookup 0x44 -> pred_taken=1, pred_target=32'h100.
REQ-037 SHALL test: three not-taken updates on that entry -> counter 11->10->01->00, pred_taken=0; a fourth stays at 00.
REQ-038 SHALL test: taken update at pc=32'h0000_1044 (same index, new tag) -> tag replaced, counter=10; lookup 0x44 -> pred_taken=0; lookup 0x1044 -> pred_taken=1.
REQ-039 SHALL test: clear_req with an update in the same cycle -> busy high 16 cycles, update dropped, branch_cnt unchanged, all lookups not taken afterwards.
REQ-040 SHALL test: 65540 updates with upd_mispredict=1 -> branch_cnt=mispred_cnt=16'hFFFF; upd_en=0 with upd_valid=1 -> no change.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and sizing for the branch predictor controller.
//   BPRED_IDX_W / BPRED_TAG_W : table index width and stored tag width
//   BPRED_ENTRIES             : number of table entries
//   bpred_state_t             : controller FSM states (IDLE, CLEAR)
//   bpred_ctr_t               : 2-bit saturating direction counter encoding
package cpu_types_pkg;

    localparam int BPRED_IDX_W   = 4;
    localparam int BPRED_TAG_W   = 26;
    localparam int BPRED_ENTRIES = 1 << BPRED_IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bpred_state_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpred_ctr_t;

    // 16-bit statistics increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bpred_ctrl_sat_counter2.sv
// Next-value logic for a 2-bit saturating direction counter.
//   cur   : present counter value
//   taken : resolved outcome (1 = count up, 0 = count down)
//   next  : counter value after applying the outcome
module sat_counter2
    import cpu_types_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (taken) begin
            if (cur != STRONG_T) begin
                next = cur + 2'd1;
            end
        end else begin
            if (cur != STRONG_NT) begin
                next = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bpred_ctrl.sv
// Direct-mapped branch predictor: 16 entries of {valid, tag, target, 2-bit
// counter}, combinational lookup, single-port update from the MEM stage,
// a 16-cycle table clear sequence and saturating branch statistics.
//   CLK, nRST          : rising-edge clock, async active-low reset
//   pc                 : fetch PC to look up
//   pred_taken         : lookup hit with a taken-leaning counter
//   pred_target        : predicted target, zero when not predicting taken
//   upd_*              : resolved branch (valid, advance, pc, outcome, target,
//                        mispredict flag)
//   clear_req          : start invalidating the whole table
//   busy               : clear in progress
//   branch_cnt         : applied updates (saturating)
//   mispred_cnt        : applied updates flagged as mispredicts (saturating)
//
// state | meaning
// IDLE  | lookups and updates active, waiting for clear_req
// CLEAR | invalidating one entry per cycle, updates dropped, no predictions
module bpred_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        clear_req,
    output logic        busy,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    logic [BPRED_ENTRIES-1:0] valid_q;
    logic [BPRED_TAG_W-1:0]   tag_q    [BPRED_ENTRIES];
    logic [31:0]              target_q [BPRED_ENTRIES];
    logic [1:0]               ctr_q    [BPRED_ENTRIES];

    bpred_state_t             state_q;
    logic [BPRED_IDX_W-1:0]   clr_idx_q;
    logic                     busy_q;

    // Two low PC bits are always zero for aligned instructions.
    logic                     unused_pc_bits;
    assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

    // ---------------- lookup ----------------
    logic [BPRED_IDX_W-1:0] lk_idx;
    logic [BPRED_TAG_W-1:0] lk_tag;
    logic                   lk_hit;

    assign lk_idx = pc[5:2];
    assign lk_tag = pc[31:6];
    assign lk_hit = (state_q == IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : 32'h0;

    // ---------------- update ----------------
    logic [BPRED_IDX_W-1:0] upd_idx;
    logic [BPRED_TAG_W-1:0] upd_tag;
    logic                   upd_hit;
    logic                   upd_fire;
    logic [1:0]             ctr_next;
    logic [1:0]             ctr_wr;

    assign upd_idx = upd_pc[5:2];
    assign upd_tag = upd_pc[31:6];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // A same-cycle clear request wins over the update.
    assign upd_fire = upd_valid && upd_en && (state_q == IDLE) && !clear_req;

    sat_counter2 u_sat (
        .cur   (ctr_q[upd_idx]),
        .taken (upd_taken),
        .next  (ctr_next)
    );

    // A taken branch that misses allocates the entry fresh as weakly taken
    // instead of inheriting the evicted branch's history.
    assign ctr_wr = (upd_taken && !upd_hit) ? WEAK_T : ctr_next;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == {BPRED_IDX_W{1'b1}}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // ---------------- table ----------------
    // Tags and targets are left stale by a clear; valid=0 masks them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < BPRED_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WEAK_NT;
            end
        end else if (state_q == CLEAR) begin
            valid_q[clr_idx_q] <= 1'b0;
            ctr_q[clr_idx_q]   <= WEAK_NT;
        end else if (upd_fire) begin
            ctr_q[upd_idx] <= ctr_wr;
            if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
            end
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_fire) begin
            branch_cnt <= sat_inc16(branch_cnt);
            if (upd_mispredict) begin
                mispred_cnt <= sat_inc16(mispred_cnt);
            end
        end
    end

endmodule
